// File: rtl/mode_counter_if.sv
// Control, configuration and status bundle for mode_counter.
// The master drives commands and configuration; the slave returns count and status.
interface mode_counter_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             up;
    logic [1:0]       mode;
    logic [WIDTH-1:0] increment;
    logic [WIDTH-1:0] min_value;
    logic [WIDTH-1:0] max_value;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             wrap_pulse;
    logic             done;
    logic             dir;
    logic             cfg_err;

    modport master (
        output clear, load, load_value, enable, up, mode,
               increment, min_value, max_value,
        input  count, carry, wrap_pulse, done, dir, cfg_err
    );

    modport slave (
        input  clear, load, load_value, enable, up, mode,
               increment, min_value, max_value,
        output count, carry, wrap_pulse, done, dir, cfg_err
    );
endinterface

// File: rtl/mode_counter.sv
// Runtime-configurable step counter with wrap, saturate, one-shot and bounce
// terminal behaviour, parallel load, synchronous clear and config checking.
module mode_counter #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic          clk,
    input  logic          reset,
    mode_counter_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'd0,
        MODE_SATURATE = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_BOUNCE   = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             dir_q, dir_d;
    logic             pulse_q, pulse_d;

    mode_e            mode;
    logic             eff_up;
    logic             cfg_err;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   floor_x;
    logic             up_cross;
    logic             down_cross;
    logic             crossing;
    logic             step;
    logic [WIDTH-1:0] top_value;
    logic [WIDTH-1:0] clamp_value;
    logic [WIDTH-1:0] start_value;

    assign mode    = mode_e'(bus.mode);
    assign cfg_err = bus.min_value >= bus.max_value;
    assign eff_up  = (mode == MODE_BOUNCE) ? dir_q : bus.up;

    // One extra bit keeps count+increment and min+increment from aliasing.
    assign sum_x      = {1'b0, count_q} + {1'b0, bus.increment};
    assign floor_x    = {1'b0, bus.min_value} + {1'b0, bus.increment};
    assign up_cross   = sum_x >= {1'b0, bus.max_value};
    assign down_cross = {1'b0, count_q} < floor_x;
    assign crossing   = eff_up ? up_cross : down_cross;

    assign step        = bus.enable & ~done_q & ~cfg_err;
    assign top_value   = bus.max_value - ONE;
    assign clamp_value = eff_up ? top_value : bus.min_value;
    assign start_value = eff_up ? bus.min_value : top_value;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned and infers a latch.
        count_d = count_q;
        done_d  = done_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;

        if (bus.clear) begin
            count_d = RESET_VALUE;
            done_d  = 1'b0;
            dir_d   = bus.up;
        end else if (bus.load) begin
            count_d = bus.load_value;
            done_d  = 1'b0;
            dir_d   = bus.up;
        end else if (step) begin
            if (!crossing) begin
                count_d = eff_up ? (count_q + bus.increment) : (count_q - bus.increment);
            end else begin
                unique case (mode)
                    MODE_WRAP: begin
                        count_d = start_value;
                        pulse_d = 1'b1;
                    end
                    MODE_SATURATE: begin
                        // A count already parked on the bound produces no repeat pulse.
                        count_d = clamp_value;
                        pulse_d = count_q != clamp_value;
                    end
                    MODE_ONESHOT: begin
                        count_d = start_value;
                        done_d  = 1'b1;
                        pulse_d = 1'b1;
                    end
                    MODE_BOUNCE: begin
                        count_d = clamp_value;
                        dir_d   = ~dir_q;
                        pulse_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VALUE;
            done_q  <= 1'b0;
            dir_q   <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.carry      = crossing & ~done_q & ~cfg_err;
    assign bus.wrap_pulse = pulse_q;
    assign bus.done       = done_q;
    assign bus.dir        = eff_up;
    assign bus.cfg_err    = cfg_err;

endmodule

// File: tb/tb_mode_counter.sv
// Directed table-driven bench for mode_counter (WIDTH=8, RESET_VALUE=20).
// Each record holds the inputs for one clock edge and the outputs expected after it.
module tb_mode_counter;

    typedef struct {
        string      name;
        logic       clear;
        logic       load;
        logic [7:0] load_value;
        logic       enable;
        logic       up;
        logic [1:0] mode;
        logic [7:0] increment;
        logic [7:0] min_value;
        logic [7:0] max_value;
        logic [7:0] e_count;
        logic       e_carry;
        logic       e_pulse;
        logic       e_done;
        logic       e_dir;
        logic       e_cfg;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    mode_counter_if #(.WIDTH(8)) bus ();

    mode_counter #(.WIDTH(8), .RESET_VALUE(8'd20)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic cl, input logic ld,
                                input logic [7:0] lv, input logic en, input logic up,
                                input logic [1:0] md, input logic [7:0] inc,
                                input logic [7:0] mn, input logic [7:0] mx,
                                input logic [7:0] ec, input logic ecy, input logic ep,
                                input logic ed, input logic edr, input logic ecf);
        vec_t v;
        v.name = n; v.clear = cl; v.load = ld; v.load_value = lv; v.enable = en;
        v.up = up; v.mode = md; v.increment = inc; v.min_value = mn; v.max_value = mx;
        v.e_count = ec; v.e_carry = ecy; v.e_pulse = ep; v.e_done = ed; v.e_dir = edr;
        v.e_cfg = ecf;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        bus.clear      = v.clear;
        bus.load       = v.load;
        bus.load_value = v.load_value;
        bus.enable     = v.enable;
        bus.up         = v.up;
        bus.mode       = v.mode;
        bus.increment  = v.increment;
        bus.min_value  = v.min_value;
        bus.max_value  = v.max_value;
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check({v.name, ".count"}, 32'(bus.count), 32'(v.e_count));
        check({v.name, ".carry"}, 32'(bus.carry), 32'(v.e_carry));
        check({v.name, ".wrap_pulse"}, 32'(bus.wrap_pulse), 32'(v.e_pulse));
        check({v.name, ".done"}, 32'(bus.done), 32'(v.e_done));
        check({v.name, ".dir"}, 32'(bus.dir), 32'(v.e_dir));
        check({v.name, ".cfg_err"}, 32'(bus.cfg_err), 32'(v.e_cfg));
    endtask

    initial begin
        vec_t hv;

        //   name        cl ld lv   en up md inc mn max   count cy p d dir cfg
        // Wrap up from RESET_VALUE=20 over [20,99] by 10
        add("wrap_up30", 0, 0, 0,   1, 1, 0, 10, 20, 100, 30,  0, 0, 0, 1, 0);
        add("wrap_up40", 0, 0, 0,   1, 1, 0, 10, 20, 100, 40,  0, 0, 0, 1, 0);
        add("wrap_up50", 0, 0, 0,   1, 1, 0, 10, 20, 100, 50,  0, 0, 0, 1, 0);
        add("wrap_up60", 0, 0, 0,   1, 1, 0, 10, 20, 100, 60,  0, 0, 0, 1, 0);
        add("wrap_up70", 0, 0, 0,   1, 1, 0, 10, 20, 100, 70,  0, 0, 0, 1, 0);
        add("wrap_up80", 0, 0, 0,   1, 1, 0, 10, 20, 100, 80,  0, 0, 0, 1, 0);
        add("wrap_up90", 0, 0, 0,   1, 1, 0, 10, 20, 100, 90,  1, 0, 0, 1, 0);
        add("wrap_up20", 0, 0, 0,   1, 1, 0, 10, 20, 100, 20,  0, 1, 0, 1, 0);
        add("wrap_upnx", 0, 0, 0,   1, 1, 0, 10, 20, 100, 30,  0, 0, 0, 1, 0);
        // Wrap down over [0,15] by 3
        add("wrap_dnld", 0, 1, 5,   1, 0, 0, 3,  0,  16,  5,   0, 0, 0, 0, 0);
        add("wrap_dn2",  0, 0, 0,   1, 0, 0, 3,  0,  16,  2,   1, 0, 0, 0, 0);
        add("wrap_dn15", 0, 0, 0,   1, 0, 0, 3,  0,  16,  15,  0, 1, 0, 0, 0);
        add("wrap_dn12", 0, 0, 0,   1, 0, 0, 3,  0,  16,  12,  0, 0, 0, 0, 0);
        // Saturate near the 8-bit ceiling
        add("sat_ld",    0, 1, 240, 1, 1, 1, 10, 0,  255, 240, 0, 0, 0, 1, 0);
        add("sat_250",   0, 0, 0,   1, 1, 1, 10, 0,  255, 250, 1, 0, 0, 1, 0);
        add("sat_254",   0, 0, 0,   1, 1, 1, 10, 0,  255, 254, 1, 1, 0, 1, 0);
        add("sat_hold1", 0, 0, 0,   1, 1, 1, 10, 0,  255, 254, 1, 0, 0, 1, 0);
        add("sat_hold2", 0, 0, 0,   1, 1, 1, 10, 0,  255, 254, 1, 0, 0, 1, 0);
        // One-shot over [0,3]
        add("os_ld",     0, 1, 0,   1, 1, 2, 1,  0,  4,   0,   0, 0, 0, 1, 0);
        add("os_1",      0, 0, 0,   1, 1, 2, 1,  0,  4,   1,   0, 0, 0, 1, 0);
        add("os_2",      0, 0, 0,   1, 1, 2, 1,  0,  4,   2,   0, 0, 0, 1, 0);
        add("os_3",      0, 0, 0,   1, 1, 2, 1,  0,  4,   3,   1, 0, 0, 1, 0);
        add("os_done",   0, 0, 0,   1, 1, 2, 1,  0,  4,   0,   0, 1, 1, 1, 0);
        add("os_idle",   0, 0, 0,   1, 1, 2, 1,  0,  4,   0,   0, 0, 1, 1, 0);
        add("os_clear",  1, 0, 0,   1, 1, 2, 1,  0,  4,   20,  1, 0, 0, 1, 0);
        add("os_again",  0, 0, 0,   1, 1, 2, 1,  0,  4,   0,   0, 1, 1, 1, 0);
        add("os_reld",   0, 1, 0,   1, 1, 2, 1,  0,  4,   0,   0, 0, 0, 1, 0);
        add("os_resume", 0, 0, 0,   1, 1, 2, 1,  0,  4,   1,   0, 0, 0, 1, 0);
        // Bounce over [0,7] by 2; up input low afterwards shows dir comes from the register
        add("bn_ld",     0, 1, 0,   1, 1, 3, 2,  0,  8,   0,   0, 0, 0, 1, 0);
        add("bn_2",      0, 0, 0,   1, 0, 3, 2,  0,  8,   2,   0, 0, 0, 1, 0);
        add("bn_4",      0, 0, 0,   1, 0, 3, 2,  0,  8,   4,   0, 0, 0, 1, 0);
        add("bn_6",      0, 0, 0,   1, 0, 3, 2,  0,  8,   6,   1, 0, 0, 1, 0);
        add("bn_7",      0, 0, 0,   1, 0, 3, 2,  0,  8,   7,   0, 1, 0, 0, 0);
        add("bn_5",      0, 0, 0,   1, 0, 3, 2,  0,  8,   5,   0, 0, 0, 0, 0);
        add("bn_3",      0, 0, 0,   1, 0, 3, 2,  0,  8,   3,   0, 0, 0, 0, 0);
        add("bn_1",      0, 0, 0,   1, 0, 3, 2,  0,  8,   1,   1, 0, 0, 0, 0);
        add("bn_0",      0, 0, 0,   1, 0, 3, 2,  0,  8,   0,   0, 1, 0, 1, 0);
        add("bn_2b",     0, 0, 0,   1, 0, 3, 2,  0,  8,   2,   0, 0, 0, 1, 0);
        // Priority: clear beats load beats enable
        add("pri_cl_ld", 1, 1, 50,  1, 1, 0, 10, 0,  100, 20,  0, 0, 0, 1, 0);
        add("pri_ld50",  0, 1, 50,  0, 1, 0, 10, 0,  100, 50,  0, 0, 0, 1, 0);

        bus.clear = 1'b0; bus.load = 1'b0; bus.load_value = '0; bus.enable = 1'b0;
        bus.up = 1'b0; bus.mode = 2'd3; bus.increment = 8'd10;
        bus.min_value = 8'd20; bus.max_value = 8'd100;
        reset = 1'b1;
        #12;
        // In bounce mode with up=0, dir must show the register's reset value of 1
        check("rst.count", 32'(bus.count), 32'd20);
        check("rst.wrap_pulse", 32'(bus.wrap_pulse), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.dir", 32'(bus.dir), 32'd1);
        check("rst.carry", 32'(bus.carry), 32'd0);
        drive(vecs[0]);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset mid-count: count must return before any clock edge
        hv = vecs[vecs.size()-1];
        hv.load = 1'b0;
        drive(hv);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst.count", 32'(bus.count), 32'd20);
        check("arst.done", 32'(bus.done), 32'd0);
        check("arst.wrap_pulse", 32'(bus.wrap_pulse), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // min == max flags cfg_err and freezes the count despite enable
        hv = vecs[0];
        hv.name = "cfg_err1"; hv.min_value = 8'd10; hv.max_value = 8'd10; hv.increment = 8'd10;
        hv.e_count = 8'd20; hv.e_carry = 1'b0; hv.e_pulse = 1'b0; hv.e_done = 1'b0;
        hv.e_dir = 1'b1; hv.e_cfg = 1'b1;
        apply(hv);
        hv.name = "cfg_err2";
        apply(hv);

        // increment=0 holds the count while in range
        hv.name = "inc0_hold"; hv.min_value = 8'd0; hv.max_value = 8'd100;
        hv.increment = 8'd0; hv.e_cfg = 1'b0;
        apply(hv);
        // increment=0 with count == max still crosses and wraps to min
        hv.name = "inc0_cross"; hv.max_value = 8'd20;
        hv.e_count = 8'd0; hv.e_pulse = 1'b1;
        apply(hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
Runtime-configurable step counter; successor to the fixed-parameter up-counter used for timing and generation pacing.
- Bounds, step, direction and terminal behaviour (wrap, saturate, one-shot, bounce) are all inputs, so one instance serves pixel/line timing, cell-scan and frame-rate dividers.
- Adds parallel load, synchronous clear, a registered terminal pulse and configuration-error detection.

Parameters:
WIDTH, 8, bit width of count and all value inputs.
RESET_VALUE, 0, count value after reset or clear.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous clear to RESET_VALUE.
load  input  1  synchronous parallel load.
load_value  input  WIDTH  value taken on load.
enable  input  1  advance one step this cycle.
up  input  1  direction, 1=up, 0=down; in bounce mode, seeds the direction register on clear/load.
mode  input  2  0=wrap, 1=saturate, 2=one-shot, 3=bounce.
increment  input  WIDTH  step size, unsigned.
min_value  input  WIDTH  lower bound, inclusive.
max_value  input  WIDTH  upper bound, exclusive; legal range is [min_value, max_value-1].
count  output  WIDTH  current value.
carry  output  1  combinational: the next enabled step crosses a bound.
wrap_pulse  output  1  registered one-cycle pulse on each bound event.
done  output  1  sticky; one-shot mode has terminated.
dir  output  1  effective direction (1=up).
cfg_err  output  1  combinational: min_value >= max_value.

Behaviour:
- Reset values (async, immediate, no clock edge needed): count=RESET_VALUE, wrap_pulse=0, done=0, dir register=1.
- Priority per edge: reset > clear > load > enable step.
- clear: count<=RESET_VALUE, done<=0, dir register<=up, wrap_pulse<=0.
- load: count<=load_value, done<=0, dir register<=up, wrap_pulse<=0. Out-of-range loads are taken as-is; the next step evaluates crossing normally.
- Effective direction: dir register when mode=3, otherwise the up input. Output dir shows the effective direction.
- Arithmetic is WIDTH+1 bits, so no overflow aliasing.
  - Up crossing: count+increment >= max_value.
  - Down crossing: count < min_value+increment.
- carry = crossing & ~done & ~cfg_err. It does not depend on enable.
- Config inputs are sampled every cycle, not latched. Changes take effect on the next step.
- Step when enable=1 and done=0 and cfg_err=0:
  - No crossing: count <= count ± increment.
  - Crossing, mode 0 (wrap): up -> min_value; down -> max_value-1; wrap_pulse<=1.
  - Crossing, mode 1 (saturate): up -> max_value-1; down -> min_value. wrap_pulse<=1 only if count differs from that bound; a held count at the bound gives no further pulses, and carry stays 1.
  - Crossing, mode 2 (one-shot): count -> start bound (min_value if up, max_value-1 if down); done<=1; wrap_pulse<=1. Enable is then ignored until clear, load or reset.
  - Crossing, mode 3 (bounce): clamp to the bound (as in saturate), invert dir register, wrap_pulse<=1.
- wrap_pulse is 0 on any cycle without a crossing step. It is high for exactly one cycle after the edge that performed the bound event.
- increment=0: count holds. Crossing is evaluated normally; e.g. up crossing is true if count >= max_value.
- cfg_err=1: count, done and dir hold; wrap_pulse=0. clear and load still act.
- Mode change mid-run: takes effect next step; done persists until cleared even if mode leaves 2.

Test Plan:
1. Wrap up: RESET_VALUE=20, min 20, max 100, inc 10, up, mode 0, enable held.
   -> 20,30,...,90 (carry=1 at 90), then 20; wrap_pulse high in the cycle count=20.
2. Wrap down: min 0, max 16, inc 3, load 5, up=0, mode 0.
   -> 5, 2 (carry=1), 15; wrap_pulse once.
3. Saturate plus overflow: WIDTH=8, min 0, max 255, inc 10, load 240, mode 1.
   -> 250 (carry=1 since 260>=255), 254 with one wrap_pulse; then holds 254, carry=1, no further pulses.
4. One-shot: min 0, max 4, inc 1, mode 2.
   -> 0,1,2,3, then 0 with done=1 and one pulse; further enable leaves count=0. clear -> done=0 and counting resumes.
5. Bounce: min 0, max 8, inc 2, mode 3, clear with up=1.
   -> 0,2,4,6,7 (dir->0), 5,3,1,0 (dir->1), 2; pulses at 7 and at 0.
6. Priority/reset: clear+load same edge -> count=RESET_VALUE. Assert reset asynchronously mid-count at 50 -> count=RESET_VALUE before the next clk edge. min 10, max 10 -> cfg_err=1 and count frozen.
